// File: rtl/seq_ctrl_ws_pkg.sv
// seq_ctrl_ws_pkg: shared opcode/phase types, default sizes and opcode helpers for the sequencer
package seq_ctrl_ws_pkg;
  typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } state_t;
  localparam int TIMEOUT_DEF = 15;
  localparam int TO_W_DEF = 4;
  localparam int CNT_W_DEF = 16;
  function automatic logic is_aluop(opcode_t op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction
  // Phases are encoded in cycle order, so STORE + 1 wraps to INST_ADDR.
  function automatic state_t next_phase(state_t s);
    return state_t'(s + 3'd1);
  endfunction
endpackage

// File: rtl/seq_ctrl_ws_if.sv
// seq_ctrl_ws_if: sequencer <-> IR/datapath/memory signal bundle
//   master: sequencer side (takes opcode/zero/mem_rdy/go, drives strobes, status, phase, retired)
//   slave : datapath/memory side
interface seq_ctrl_ws_if import seq_ctrl_ws_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
  opcode_t opcode;
  logic zero;
  logic mem_rdy;
  logic go;
  logic mem_rd;
  logic mem_wr;
  logic load_ir;
  logic load_ac;
  logic load_pc;
  logic inc_pc;
  logic data_e;
  logic halt;
  logic err;
  state_t phase;
  logic [CNT_W-1:0] retired;
  modport master (
    input opcode, zero, mem_rdy, go,
    output mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt, err, phase, retired
  );
  modport slave (
    output opcode, zero, mem_rdy, go,
    input mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt, err, phase, retired
  );
endinterface

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: counts consecutive wait cycles in one phase and flags the timeout
//   clk, rst_  : clock, async active-low reset
//   wait_i     : current phase is a wait phase
//   rdy_i      : memory ready
//   timeout_o  : last tolerated wait cycle passing with rdy_i still low
module seq_wait_timer #(
  parameter int TO_W = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_,
  input  logic wait_i,
  input  logic rdy_i,
  output logic timeout_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic stall;
  assign stall = wait_i && !rdy_i;
  assign timeout_o = stall && (cnt_q == TO_W'(TIMEOUT - 1));
  assign cnt_d = (stall && !timeout_o) ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/seq_ctrl_ws.sv
// seq_ctrl_ws: eight-phase instruction sequencer with memory wait-states, timeout halt, resumable HLT
//   clk, rst_ : clock, async active-low reset
//   bus       : master side of seq_ctrl_ws_if (opcode/zero/mem_rdy/go in; strobes, halt, err, phase, retired out)
module seq_ctrl_ws import seq_ctrl_ws_pkg::*; #(
  parameter bit WAIT_EN = 1'b1,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W = TO_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst_,
  seq_ctrl_ws_if.master bus
);
  state_t state_q, state_d;
  logic halt_q, halt_d, err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic alu, sto, jmp, skz, hlt, wait_ph, timeout, live;
  assign alu = is_aluop(bus.opcode);
  assign sto = bus.opcode == STO;
  assign jmp = bus.opcode == JMP;
  assign skz = bus.opcode == SKZ;
  assign hlt = bus.opcode == HLT;
  assign wait_ph = WAIT_EN && !err_q &&
                   (state_q == INST_LOAD || (state_q == ALU_OP && alu) || (state_q == STORE && sto));
  seq_wait_timer #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_tmr (
    .clk(clk),
    .rst_(rst_),
    .wait_i(wait_ph),
    .rdy_i(bus.mem_rdy),
    .timeout_o(timeout)
  );
  // HLT halts in OP_ADDR after its single inc_pc cycle; go on that same cycle skips the halt.
  always_comb begin
    state_d = state_q;
    halt_d = halt_q;
    err_d = err_q;
    retired_d = retired_q;
    if (err_q) begin
    end else if (timeout) begin
      err_d = 1'b1;
    end else if (state_q == OP_ADDR && hlt) begin
      state_d = bus.go ? OP_FETCH : OP_ADDR;
      halt_d = !bus.go;
    end else if (!(wait_ph && !bus.mem_rdy)) begin
      state_d = next_phase(state_q);
      retired_d = state_q == STORE ? retired_q + 1'b1 : retired_q;
    end
  end
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      state_q <= INST_ADDR;
      halt_q <= 1'b0;
      err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q <= halt_d;
      err_q <= err_d;
      retired_q <= retired_d;
    end
  // Halted cycles (HLT or error) silence every strobe; OP_ADDR's inc_pc is thus first-cycle only.
  assign live = !err_q && !halt_q;
  assign bus.mem_rd = live && (state_q inside {INST_FETCH, INST_LOAD, IDLE} ||
                               (state_q inside {OP_FETCH, ALU_OP, STORE} && alu));
  assign bus.load_ir = live && state_q inside {INST_LOAD, IDLE};
  assign bus.load_ac = live && state_q inside {ALU_OP, STORE} && alu;
  assign bus.inc_pc = live && (state_q == OP_ADDR || (state_q == ALU_OP && skz && bus.zero) ||
                               (state_q == STORE && jmp));
  assign bus.load_pc = live && state_q inside {ALU_OP, STORE} && jmp;
  assign bus.data_e = live && state_q inside {ALU_OP, STORE} && sto;
  assign bus.mem_wr = live && state_q == STORE && sto;
  assign bus.halt = halt_q || err_q;
  assign bus.err = err_q;
  assign bus.phase = state_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_seq_ctrl_ws.sv
// tb_seq_ctrl_ws: directed scoreboard bench for seq_ctrl_ws (TIMEOUT=4, CNT_W=2)
module tb_seq_ctrl_ws;
  import seq_ctrl_ws_pkg::*;
  localparam logic [6:0] RD = 7'b1000000, WR = 7'b0100000, IR = 7'b0010000, AC = 7'b0001000,
                         LP = 7'b0000100, IP = 7'b0000010, DE = 7'b0000001, NO = 7'b0000000;
  typedef struct packed {
    state_t ph;
    logic [6:0] st;
    logic halt;
    logic err;
    logic [1:0] ret;
  } exp_t;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [1:0] exp_ret = '0;
  always #5 clk = ~clk;
  seq_ctrl_ws_if #(.CNT_W(2)) bus ();
  seq_ctrl_ws #(.WAIT_EN(1'b1), .TIMEOUT(4), .TO_W(4), .CNT_W(2)) dut (
    .clk(clk),
    .rst_(rst_),
    .bus(bus)
  );
  function automatic logic [6:0] model_st(state_t p, opcode_t op, logic z);
    logic a;
    a = op inside {ADD, AND, XOR, LDA};
    case (p)
      INST_FETCH: return RD;
      INST_LOAD, IDLE: return RD | IR;
      OP_ADDR: return IP;
      OP_FETCH: return a ? RD : NO;
      ALU_OP: return (a ? RD | AC : NO) | ((op == SKZ && z) ? IP : NO) |
                     (op == JMP ? LP : NO) | (op == STO ? DE : NO);
      STORE: return (a ? RD | AC : NO) | (op == JMP ? LP | IP : NO) | (op == STO ? DE | WR : NO);
      default: return NO;
    endcase
  endfunction
  task automatic push(state_t ph, logic [6:0] st, logic h, logic e);
    exp_t x;
    x.ph = ph;
    x.st = st;
    x.halt = h;
    x.err = e;
    x.ret = exp_ret;
    sb.push_back(x);
  endtask
  task automatic chk(string tag);
    exp_t e, o;
    e = sb.pop_front();
    o.ph = bus.phase;
    o.st = {bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_ac, bus.load_pc, bus.inc_pc, bus.data_e};
    o.halt = bus.halt;
    o.err = bus.err;
    o.ret = bus.retired;
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed ph=%s st=%b halt=%b err=%b ret=%0d expected ph=%s st=%b halt=%b err=%b ret=%0d",
             tag, o.ph.name(), o.st, o.halt, o.err, o.ret, e.ph.name(), e.st, e.halt, e.err, e.ret);
    end
  endtask
  task automatic cyc(string tag, state_t ph, logic [6:0] st, logic h, logic e);
    push(ph, st, h, e);
    @(negedge clk);
    chk(tag);
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(opcode_t op, logic z, int nw, int hcyc);
    state_t p;
    logic w;
    bus.opcode = op;
    bus.zero = z;
    bus.go = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p = state_t'(i);
      w = p == INST_LOAD || (p == ALU_OP && is_aluop(op)) || (p == STORE && op == STO);
      if (p == OP_ADDR && op == HLT) begin
        bus.mem_rdy = 1'b0;
        bus.go = hcyc == 0;
        cyc("hlt_inc", OP_ADDR, IP, 1'b0, 1'b0);
        for (int k = 0; k < hcyc; k++) begin
          bus.go = k == hcyc - 1;
          cyc("hlt_hold", OP_ADDR, NO, 1'b1, 1'b0);
        end
        bus.go = 1'b0;
      end else begin
        if (w)
          for (int k = 0; k < nw; k++) begin
            bus.mem_rdy = 1'b0;
            cyc("wait", p, model_st(p, op, z), 1'b0, 1'b0);
          end
        bus.mem_rdy = w;
        cyc(op.name(), p, model_st(p, op, z), 1'b0, 1'b0);
      end
    end
    exp_ret++;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish by 100000");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.opcode = ADD;
    bus.zero = 1'b0;
    bus.mem_rdy = 1'b1;
    bus.go = 1'b0;
    push(INST_ADDR, NO, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset");
    @(posedge clk);
    #1 rst_ = 1'b1;
    for (int i = 0; i < 4; i++) run_instr(ADD, 1'b0, 0, 0);
    run_instr(STO, 1'b0, 3, 0);
    run_instr(LDA, 1'b0, 2, 0);
    run_instr(SKZ, 1'b1, 1, 0);
    run_instr(SKZ, 1'b0, 1, 0);
    run_instr(JMP, 1'b1, 1, 0);
    run_instr(XOR, 1'b0, 1, 0);
    run_instr(AND, 1'b1, 0, 0);
    run_instr(HLT, 1'b0, 0, 10);
    run_instr(HLT, 1'b0, 0, 0);
    bus.opcode = ADD;
    bus.mem_rdy = 1'b0;
    cyc("to_pre", INST_ADDR, NO, 1'b0, 1'b0);
    cyc("to_pre", INST_FETCH, RD, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc("to_wait", INST_LOAD, RD | IR, 1'b0, 1'b0);
    cyc("to_err", INST_LOAD, NO, 1'b1, 1'b1);
    bus.go = 1'b1;
    cyc("to_go", INST_LOAD, NO, 1'b1, 1'b1);
    bus.go = 1'b0;
    bus.mem_rdy = 1'b1;
    for (int k = 0; k < 3; k++) cyc("to_stuck", INST_LOAD, NO, 1'b1, 1'b1);
    rst_ = 1'b0;
    exp_ret = '0;
    #1;
    push(INST_ADDR, NO, 1'b0, 1'b0);
    chk("to_rst");
    @(posedge clk);
    #1 rst_ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.mem_rdy = 1'b1;
      cyc("pre_alu", state_t'(i), model_st(state_t'(i), ADD, 1'b0), 1'b0, 1'b0);
    end
    bus.mem_rdy = 1'b0;
    for (int k = 0; k < 2; k++) cyc("alu_wait", ALU_OP, RD | AC, 1'b0, 1'b0);
    rst_ = 1'b0;
    #1;
    push(INST_ADDR, NO, 1'b0, 1'b0);
    chk("async_rst");
    @(posedge clk);
    #1 rst_ = 1'b1;
    run_instr(ADD, 1'b0, 0, 0);
    push(INST_ADDR, NO, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_ctrl_ws.md
Name: seq_ctrl_ws

Overview:
- Next-generation instruction sequencer for the 8-bit CPU. Walks the eight-phase cycle INST_ADDR→STORE on opcode_t/state_t from package typedefs.
- Adds memory wait-states via a ready handshake, a wait timeout with error halt, and a resumable HLT.
- Adds a retired-instruction counter.
- Sits between the instruction register / zero flag and the datapath/memory strobes.

Parameters:
- WAIT_EN, 1, 1 = stall on mem_rdy low; 0 = mem_rdy ignored, fixed 8-cycle instruction.
- TIMEOUT, 15, max consecutive wait cycles tolerated in one phase (1..2^TO_W-1).
- TO_W, 4, width of the wait counter.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_  in  1  reset; asynchronous, active-low.
- opcode  in  opcode_t  current IR opcode, stable from IDLE onward.
- zero  in  1  accumulator-zero flag.
- mem_rdy  in  1  memory completed access this cycle.
- go  in  1  one-cycle pulse; resumes from HLT halt.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- load_ir  out  1  load instruction register.
- load_ac  out  1  load accumulator.
- load_pc  out  1  load PC (jump).
- inc_pc  out  1  increment PC.
- data_e  out  1  drive accumulator onto data bus.
- halt  out  1  halted (HLT or error).
- err  out  1  sticky wait-timeout error.
- phase  out  state_t  current phase.
- retired  out  CNT_W  instructions completed, wraps.

Behaviour:
- Reset: phase = INST_ADDR; all strobes, halt and err = 0; retired = 0; wait counter = 0.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Phase advances INST_ADDR→INST_FETCH→INST_LOAD→IDLE→OP_ADDR→OP_FETCH→ALU_OP→STORE→INST_ADDR, one per cycle, except where held below.
- Strobes are combinational from phase and opcode:
  - INST_FETCH, INST_LOAD, IDLE: mem_rd = 1.
  - INST_LOAD, IDLE: load_ir = 1.
  - OP_ADDR: inc_pc = 1 on the first cycle in the phase only.
  - OP_FETCH, ALU_OP, STORE: mem_rd = ALUOP.
  - ALU_OP, STORE: load_ac = ALUOP.
  - ALU_OP: inc_pc = (SKZ & zero); load_pc = JMP; data_e = STO.
  - STORE: inc_pc = JMP; load_pc = JMP; data_e = STO; mem_wr = STO.
- Wait phases (WAIT_EN = 1):
  - INST_LOAD always waits.
  - ALU_OP waits when ALUOP.
  - STORE waits when opcode = STO.
  - The phase holds while mem_rdy = 0. Strobes stay asserted and the wait counter increments.
  - mem_rdy = 1 advances the phase and clears the counter. mem_rdy on the first cycle gives zero wait states.
  - mem_rdy is ignored in non-wait phases.
- Timeout: a wait cycle with counter = TIMEOUT-1 and mem_rdy still 0 does the following next cycle:
  - err = 1 and halt = 1, phase frozen, all strobes 0.
  - Only rst_ clears it; go is ignored.
- HLT: entering OP_ADDR with opcode HLT gives inc_pc for one cycle (PC points past HLT), then halt = 1 with phase held in OP_ADDR and strobes 0.
  - go = 1 clears halt and advances to OP_FETCH next cycle.
  - go arriving on the inc_pc cycle itself is accepted: no halt cycle is observed.
- retired increments by 1 on each STORE→INST_ADDR transition; wraps 2^CNT_W-1 → 0.
- mem_rdy and go in the same cycle are independent; there is no case where both are acted on.
- Asynchronous reset mid-wait or mid-halt returns everything to reset values immediately. No strobe glitches after rst_ deassertion, which must be synchronous to clk.

Decomposition:
- Package typedefs already holds opcode_t and state_t. Add TIMEOUT_DEF and CNT_W_DEF constants and an ALUOP membership function there.
- One natural sub-module, seq_wait_timer: the wait counter plus timeout compare, parameterised by TO_W/TIMEOUT. The FSM, strobe decode and retired counter stay in seq_ctrl_ws.

Test Plan:
- Reset, WAIT_EN = 1, mem_rdy tied 1, opcode ADD: 8 cycles per instruction. load_ac high in ALU_OP and STORE. retired = 1 after the first STORE, 3 after 24 cycles.
- STO with mem_rdy low for 3 cycles in STORE: phase held 4 cycles, mem_wr and data_e high throughout, one retired increment.
- TIMEOUT = 4, mem_rdy stuck 0 in INST_LOAD: after exactly 4 wait cycles err = 1, halt = 1, strobes 0. go pulse has no effect; rst_ low clears it.
- HLT: inc_pc pulses once, halt stays high for 10 cycles with no repeat inc_pc. go pulse → OP_FETCH next cycle, halt = 0.
- SKZ with zero = 1: inc_pc in ALU_OP. SKZ with zero = 0: none. JMP: load_pc and inc_pc in STORE.
- CNT_W = 2: after 4 instructions retired wraps to 0. rst_ asserted mid-ALU_OP wait: phase = INST_ADDR immediately, before the next clk edge.
